neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 118 +++++++++++
 tb/tb_neuron_mac.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Weighted-sum neuron: stores numWeight signed weights, multiplies each input sample by the
// next weight, accumulates with saturation and emits a saturated, shifted sum per vector.
// Optional bias register and ports are enabled by defining NEURON_MAC_BIAS_EN.
module neuron_mac #(
  parameter int numWeight  = 784,
  parameter int dataWidth  = 16,
  parameter int sigInWidth = 10,
  parameter int SHIFT      = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  weightValid,
  input  logic [dataWidth-1:0]  weightValue,
`ifdef NEURON_MAC_BIAS_EN
  input  logic                  biasValid,
  input  logic [dataWidth-1:0]  biasValue,
`endif
  input  logic [dataWidth-1:0]  myinput,
  input  logic                  myinputValid,
  output logic [sigInWidth-1:0] out,
  output logic                  outValid
);
  localparam int AW = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int PW = 2 * dataWidth;
  localparam logic [AW-1:0] LAST_IDX = AW'(numWeight - 1);
  localparam logic signed [PW-1:0] OMAX = PW'((64'sd1 <<< (sigInWidth - 1)) - 1);
  localparam logic signed [PW-1:0] OMIN = -OMAX - 1;

  logic [dataWidth-1:0]  weight_mem [numWeight];
  logic [AW-1:0]         w_addr_q, w_addr_d, r_addr_q, r_addr_d, cnt_q, cnt_d;
  logic signed [PW-1:0]  mul_q, mul_d, acc_q, acc_d, bias_al, add_bias;
  logic signed [PW-1:0]  sum_sat, sum_sh;
  logic signed [PW+1:0]  sum_w;
  logic                  mulValid_q, last;
  logic [sigInWidth-1:0] out_d;
  logic [dataWidth-1:0]  wt_rd;

  function automatic logic signed [PW-1:0] sat_pw(input logic signed [PW+1:0] v);
    logic signed [PW+1:0] hi, lo;
    hi = {3'b000, {(PW-1){1'b1}}};
    lo = {3'b111, {(PW-1){1'b0}}};
    if (v > hi)      sat_pw = hi[PW-1:0];
    else if (v < lo) sat_pw = lo[PW-1:0];
    else             sat_pw = v[PW-1:0];
  endfunction

  // Storage has no reset so weights survive an rst_n pulse.
  always_ff @(posedge clk)
    if (weightValid) weight_mem[w_addr_q] <= weightValue;

  assign wt_rd = weight_mem[r_addr_q];

`ifdef NEURON_MAC_BIAS_EN
  logic [dataWidth-1:0] bias_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         bias_q <= '0;
    else if (biasValid) bias_q <= biasValue;
  assign bias_al = {{(PW-dataWidth){bias_q[dataWidth-1]}}, bias_q} << 12;
`else
  assign bias_al = '0;
`endif

  assign last     = (cnt_q == LAST_IDX);
  assign add_bias = last ? bias_al : '0;
  // Three-term sum carried two bits wider so one saturation covers acc + product + bias.
  assign sum_w    = {{2{acc_q[PW-1]}}, acc_q} + {{2{mul_q[PW-1]}}, mul_q}
                  + {{2{add_bias[PW-1]}}, add_bias};
  assign sum_sat  = sat_pw(sum_w);
  assign sum_sh   = sum_sat >>> SHIFT;

  always_comb begin
    w_addr_d = w_addr_q;
    r_addr_d = r_addr_q;
    mul_d    = mul_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out;
    if (weightValid) w_addr_d = (w_addr_q == LAST_IDX) ? '0 : w_addr_q + 1'b1;
    if (myinputValid) begin
      r_addr_d = (r_addr_q == LAST_IDX) ? '0 : r_addr_q + 1'b1;
      mul_d    = $signed(myinput) * $signed(wt_rd);
    end
    if (mulValid_q) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
        if (sum_sh > OMAX)      out_d = OMAX[sigInWidth-1:0];
        else if (sum_sh < OMIN) out_d = OMIN[sigInWidth-1:0];
        else                    out_d = sum_sh[sigInWidth-1:0];
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr_q   <= '0;
      r_addr_q   <= '0;
      mul_q      <= '0;
      mulValid_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      out        <= '0;
      outValid   <= 1'b0;
    end else begin
      w_addr_q   <= w_addr_d;
      r_addr_q   <= r_addr_d;
      mul_q      <= mul_d;
      mulValid_q <= myinputValid;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out        <= out_d;
      outValid   <= mulValid_q && last;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac with numWeight=4: vector table, streaming, gaps, reset abort, random vectors.
// Expected outputs are queued with their due cycle when the last input is driven.
module tb_neuron_mac;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       weightValid = 1'b0;
  logic [15:0] weightValue = '0;
  logic [15:0] myinput = '0;
  logic       myinputValid = 1'b0;
  logic [9:0] out;
  logic       outValid;
`ifdef NEURON_MAC_BIAS_EN
  logic       biasValid = 1'b0;
  logic [15:0] biasValue = '0;
`endif

  neuron_mac #(.numWeight(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .weightValid(weightValid), .weightValue(weightValue),
`ifdef NEURON_MAC_BIAS_EN
    .biasValid(biasValid), .biasValue(biasValue),
`endif
    .myinput(myinput), .myinputValid(myinputValid),
    .out(out), .outValid(outValid)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][15:0] quad_t;
  typedef struct packed {
    quad_t w;
    quad_t x;
    logic [1:0] gap;
    logic signed [9:0] exp;
  } vec_t;
  typedef struct { int val; int cyc; } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic signed [9:0] prev_out = '0;
  bit   prev_ok = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(quad_t w, quad_t x, int gap, int e);
    vec_t v;
    v.w = w; v.x = x; v.gap = 2'(gap); v.exp = 10'(e);
    return v;
  endfunction

  function automatic quad_t rep(int v);
    quad_t r;
    for (int i = 0; i < 4; i++) r[i] = 16'(v);
    return r;
  endfunction

  function automatic longint sat32(longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic int model(quad_t w, quad_t x, longint bias);
    longint acc = 0, t;
    for (int i = 0; i < 3; i++)
      acc = sat32(acc + longint'($signed(w[i])) * longint'($signed(x[i])));
    t = sat32(acc + longint'($signed(w[3])) * longint'($signed(x[3])) + (bias <<< 12));
    t = t >>> 22;
    if (t > 511) t = 511;
    if (t < -512) t = -512;
    return int'(t);
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(quad_t w);
    for (int i = 0; i < 4; i++) begin
      weightValid = 1'b1;
      weightValue = w[i];
      tick();
    end
    weightValid = 1'b0;
  endtask

  // push: queue the expected result; cleared for an aborted vector
  task automatic send(quad_t x, int gap, int n, bit push, int e);
    for (int i = 0; i < n; i++) begin
      myinputValid = 1'b1;
      myinput = x[i];
      if (push && i == 3) q.push_back('{val: e, cyc: cyc + 2});
      tick();
      if (gap > 0 && i < n - 1) begin
        myinputValid = 1'b0;
        repeat (gap) tick();
      end
    end
    myinputValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("pending_outputs", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (outValid) begin
        if (q.size() == 0) begin
          check("unexpected_outValid", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_value", int'($signed(out)), e.val);
          check("out_latency_cycle", cyc, e.cyc);
        end
      end else if (prev_ok) begin
        check("out_held", int'($signed(out)), int'(prev_out));
      end
    end
    prev_out = $signed(out);
    prev_ok  = rst_n;
  end

  vec_t tbl[8];
  quad_t rw, rx;

  initial begin
    tbl[0] = mk(rep(4096), rep(4096), 0, 16);
    tbl[1] = mk(rep(32767), rep(32767), 0, 511);
    tbl[2] = mk(rep(32767), rep(-32767), 0, -512);
    tbl[3] = mk(rep(4096), rep(4096), 2, 16);
    tbl[4] = mk({16'd2048, -16'sd4096, 16'd8192, 16'd4096},
                {16'd8192, 16'd4096, 16'd4096, 16'd4096}, 0, 12);
    tbl[5] = mk(rep(-4096), rep(4096), 1, -16);
    tbl[6] = mk({16'd0, 16'd0, 16'd0, 16'd1}, {16'd0, 16'd0, 16'd0, -16'sd1}, 0, -1);
    // Accumulator clips after the third product, so the last negative term lands at 256.
    tbl[7] = mk({-16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767}, rep(32767), 0, 256);

    #2;
    check("reset_out", int'($signed(out)), 0);
    check("reset_outValid", int'(outValid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[k]) begin
      load_w(tbl[k].w);
      send(tbl[k].x, int'(tbl[k].gap), 4, 1'b1, int'(tbl[k].exp));
    end
    drain();

    // Two vectors streamed back to back: outputs due 4 cycles apart.
    load_w(rep(4096));
    send(rep(4096), 0, 4, 1'b1, 16);
    send(rep(8192), 0, 4, 1'b1, 32);
    drain();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        rw[i] = 16'(int'($urandom_range(16384)) - 8192);
        rx[i] = 16'(int'($urandom_range(65535)));
      end
      load_w(rw);
      send(rx, r % 2, 4, 1'b1, model(rw, rx, 0));
    end
    drain();

    // Reset mid-vector: partial sum dropped, weights kept.
    load_w(rep(4096));
    send(rep(4096), 0, 2, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_out", int'($signed(out)), 0);
    check("midreset_outValid", int'(outValid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(rep(4096), 0, 4, 1'b1, 16);
    drain();

`ifdef NEURON_MAC_BIAS_EN
    // bias 1.0 aligned to 2^24, then >>> 22 gives 4
    biasValid = 1'b1;
    biasValue = 16'd4096;
    tick();
    biasValid = 1'b0;
    load_w(rep(4096));
    send(rep(0), 0, 4, 1'b1, model(rep(4096), rep(0), 4096));
    drain();
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
